iiitb_alu_pipe: RTL and testbench
=================================

Name: iiitb_alu_pipe

Overview:
Parametrised, handshaked successor to the 8-bit registered iiitb_alu. It accepts one operation per transfer over a valid/ready input channel, computes an 8-op ALU result plus status flags, and returns them through a single registered valid/ready output channel. MUL is a multi-cycle shift-add operation that blocks the input while it runs. It sits between the instruction-issue logic and the register write-back path.

Parameters:
WIDTH, 8, operand/result width in bits; must be >= 4.
SHW, $clog2(WIDTH), shift-amount field width (derived, not overridden).

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operand/op transfer request
in_ready  out  1  block can accept a transfer this cycle
A  in  WIDTH  operand A (unsigned; signed for V flag)
B  in  WIDTH  operand B / shift amount
op  in  3  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR, 7 MUL
out_valid  out  1  R/flags hold a result
out_ready  in  1  consumer takes result this cycle
R  out  WIDTH  result
flags  out  4  {V,C,N,Z}

Behaviour:
- Reset (async assert, sync deassert at the block's own edge): FSM=IDLE, out_valid=0, R=0, flags=0, multiplier counter=0. in_ready=0 while rst_n=0.
- Transfer: an input is accepted on an edge where in_valid && in_ready; an output is consumed on an edge where out_valid && out_ready.
- in_ready = (state==IDLE) && (!out_valid || out_ready). Combinational, with no dependency on in_valid.
- FSM states: IDLE, MUL.
  - IDLE -> MUL when op==7 is accepted.
  - MUL -> IDLE after WIDTH iterations.
- Non-MUL latency: input accepted at edge N; R/flags/out_valid are updated at edge N (visible after N). This gives 1-cycle latency, matching the registered R of the original.
- MUL latency:
  - Operands are latched at edge N.
  - One shift-add step runs per edge, N+1 .. N+WIDTH.
  - Result is loaded and out_valid=1 at edge N+WIDTH.
  - in_ready=0 from after edge N until the FSM returns to IDLE.
- out_valid clears on consume unless a new result is loaded on the same edge; a new result takes priority.
- Backpressure: out_valid && !out_ready holds R/flags stable and forces in_ready=0.
- Arithmetic (all results truncated to WIDTH):
  - ADD: C = carry-out; V = signed overflow.
  - SUB: R = A-B; C = borrow (A<B unsigned); V = signed overflow.
  - AND/OR/XOR: C=0, V=0.
  - SHL/SHR: logical shift by unsigned B.
    - B==0: R=A, C=0.
    - 1 <= B < WIDTH: C = last bit shifted out.
    - B >= WIDTH: R=0, C=0.
    - V=0 in all cases.
  - MUL: R = low WIDTH bits of A*B (unsigned); C=1 iff the high WIDTH bits are nonzero; V=0.
- Flags for all ops: Z = (R==0); N = R[WIDTH-1].
- Reset mid-MUL: the operation is abandoned, the FSM goes to IDLE, and no result is produced.
- Invalid inputs: in_valid with in_ready=0 has no effect; the source must hold A/B/op stable until the transfer completes.

Decomposition:
- Package iiitb_alu_pkg:
  - op_e enum (ADD..MUL, 3-bit)
  - state_e enum (IDLE, MUL)
  - flag index constants FLG_Z=0, FLG_N=1, FLG_C=2, FLG_V=3
- Sub-module iiitb_alu_mul_seq:
  - Parametrised WIDTH shift-add multiplier with start/done and a 2*WIDTH product.
  - The top-level instantiates it and owns the FSM, handshake and output register.

Test Plan (WIDTH=8, out_ready=1 unless stated):
- ADD: A=0x6A, B=0x3B, op=0 -> R=0xA5, flags V=1 C=0 N=1 Z=0, out_valid one edge after accept.
- SUB: A=0x6A, B=0x3B -> R=0x2F, flags all 0. Repeat with A=0x3B, B=0x6A -> R=0xD1, C=1, N=1.
- MUL: A=0x6A, B=0x3B, op=7 -> in_ready low 8 cycles; R=0x6E, C=1 at accept+8 edges. Then A=0x0F, B=0x03 -> R=0x2D, C=0.
- Shifts:
  - SHL A=0x6A, B=3 -> R=0x50, C=1.
  - SHR A=0x6A, B=1 -> R=0x35, C=0.
  - SHL B=8 -> R=0x00, Z=1, C=0.
- Backpressure: out_ready=0 for 5 cycles after an XOR (A=0xFF, B=0xFF -> R=0x00, Z=1) -> R held, in_ready=0. Releasing out_ready with a queued ADD -> back-to-back transfer, no result lost or duplicated.
- Reset mid-MUL: assert rst_n=0 at accept+4 -> out_valid=0, R=0 immediately. After release, in_ready=1 and no MUL result appears.

Source files
------------

// File: rtl/iiitb_alu_pkg.sv
// Shared types and constants for the pipelined ALU and its multiplier.
package iiitb_alu_pkg;

    // Opcode encoding presented on the op input.
    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_SHL = 3'd5,
        OP_SHR = 3'd6,
        OP_MUL = 3'd7
    } op_e;

    // Control FSM: IDLE accepts work, MUL blocks input while the multiplier runs.
    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_e;

    // Bit positions inside the 4-bit flags bus {V,C,N,Z}.
    localparam int FLG_Z = 0;
    localparam int FLG_N = 1;
    localparam int FLG_C = 2;
    localparam int FLG_V = 3;

endpackage

// File: rtl/iiitb_alu_mul_seq.sv
// Sequential shift-add multiplier: one partial product per clock, WIDTH steps.
// done_o and product_o are combinational and describe the step taking place on
// the coming edge, so the owner can capture the final product on that same edge.
module iiitb_alu_mul_seq
    import iiitb_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_i,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    output logic                 done_o,
    output logic [2*WIDTH-1:0]   product_o
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic                 busy_q;
    logic [CW-1:0]        cnt_q;
    logic [2*WIDTH-1:0]   mcand_q;
    logic [WIDTH-1:0]     mplier_q;
    logic [2*WIDTH-1:0]   prod_q;
    logic [2*WIDTH-1:0]   prod_d;

    // Next partial product: add the shifted multiplicand when the current multiplier LSB is set.
    always_comb begin
        prod_d    = prod_q + (mplier_q[0] ? mcand_q : '0);
        done_o    = busy_q && (cnt_q == LAST);
        product_o = prod_d;
    end

    // Operand latch on start, then one shift-add iteration per edge until the last bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
        end else if (start_i) begin
            busy_q   <= 1'b1;
            cnt_q    <= '0;
            mcand_q  <= {{WIDTH{1'b0}}, a_i};
            mplier_q <= b_i;
            prod_q   <= '0;
        end else if (busy_q) begin
            prod_q   <= prod_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            if (cnt_q == LAST) begin
                busy_q <= 1'b0;
                cnt_q  <= '0;
            end else begin
                cnt_q  <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/iiitb_alu_pipe.sv
// Handshaked ALU: single-cycle ops load the output register on the accept edge;
// MUL runs on the sequential multiplier and loads the register when it finishes.
module iiitb_alu_pipe
    import iiitb_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  A,
    input  logic [WIDTH-1:0]  B,
    input  logic [2:0]        op,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  R,
    output logic [3:0]        flags
);

    localparam int SHW = $clog2(WIDTH);

    state_e              state_q, state_d;
    logic                out_valid_q, out_valid_d;
    logic [WIDTH-1:0]    r_q, r_d;
    logic [3:0]          flags_q, flags_d;

    logic                accept;
    logic                mul_start;
    logic                mul_done;
    logic [2*WIDTH-1:0]  mul_product;

    logic [WIDTH:0]      sum_w, diff_w, shl_w, shr_w;
    logic                big_shift;
    logic [WIDTH-1:0]    res_r;
    logic                res_c, res_v;

    // Input can be taken only when idle and the output slot is empty or draining now.
    assign in_ready  = rst_n && (state_q == S_IDLE) && (!out_valid_q || out_ready);
    assign accept    = in_valid && in_ready;
    assign mul_start = accept && (op_e'(op) == OP_MUL);

    assign out_valid = out_valid_q;
    assign R         = r_q;
    assign flags     = flags_q;

    iiitb_alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (mul_start),
        .a_i       (A),
        .b_i       (B),
        .done_o    (mul_done),
        .product_o (mul_product)
    );

    // Single-cycle datapath: the extra top bit of each intermediate carries C.
    always_comb begin
        sum_w     = {1'b0, A} + {1'b0, B};
        diff_w    = {1'b0, A} - {1'b0, B};
        shl_w     = {1'b0, A} << B[SHW-1:0];
        shr_w     = {A, 1'b0} >> B[SHW-1:0];
        big_shift = (B >= WIDTH'(WIDTH));
        res_r     = '0;
        res_c     = 1'b0;
        res_v     = 1'b0;
        case (op_e'(op))
            OP_ADD: begin
                res_r = sum_w[WIDTH-1:0];
                res_c = sum_w[WIDTH];
                res_v = (A[WIDTH-1] == B[WIDTH-1]) && (res_r[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                res_r = diff_w[WIDTH-1:0];
                res_c = diff_w[WIDTH];
                res_v = (A[WIDTH-1] != B[WIDTH-1]) && (res_r[WIDTH-1] != A[WIDTH-1]);
            end
            OP_AND: res_r = A & B;
            OP_OR:  res_r = A | B;
            OP_XOR: res_r = A ^ B;
            OP_SHL: begin
                res_r = big_shift ? '0 : shl_w[WIDTH-1:0];
                res_c = big_shift ? 1'b0 : shl_w[WIDTH];
            end
            OP_SHR: begin
                res_r = big_shift ? '0 : shr_w[WIDTH:1];
                res_c = big_shift ? 1'b0 : shr_w[0];
            end
            default: ;
        endcase
    end

    // Next-state for FSM and output register; a freshly loaded result wins over a consume.
    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q && !out_ready;
        r_d         = r_q;
        flags_d     = flags_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (op_e'(op) == OP_MUL) begin
                        state_d = S_MUL;
                    end else begin
                        out_valid_d    = 1'b1;
                        r_d            = res_r;
                        flags_d[FLG_Z] = (res_r == '0);
                        flags_d[FLG_N] = res_r[WIDTH-1];
                        flags_d[FLG_C] = res_c;
                        flags_d[FLG_V] = res_v;
                    end
                end
            end
            S_MUL: begin
                if (mul_done) begin
                    state_d        = S_IDLE;
                    out_valid_d    = 1'b1;
                    r_d            = mul_product[WIDTH-1:0];
                    flags_d[FLG_Z] = (mul_product[WIDTH-1:0] == '0);
                    flags_d[FLG_N] = mul_product[WIDTH-1];
                    flags_d[FLG_C] = |mul_product[2*WIDTH-1:WIDTH];
                    flags_d[FLG_V] = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers; reset abandons any multiply in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            r_q         <= '0;
            flags_q     <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            r_q         <= r_d;
            flags_q     <= flags_d;
        end
    end

endmodule

// File: tb/tb_iiitb_alu_pipe.sv
// Directed bench for iiitb_alu_pipe at WIDTH=8; inputs change and outputs are sampled on negedges.
module tb_iiitb_alu_pipe;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] A;
    logic [7:0] B;
    logic [2:0] op;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] R;
    logic [3:0] flags;

    int passed = 0;
    int total  = 0;

    iiitb_alu_pipe #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .R         (R),
        .flags     (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
            $display("check %s observed=%0h expected=%0h ok", tag, obs, exp);
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one operation for a single accept edge; returns at the following negedge.
    task automatic issue(input string tag, input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        in_valid = 1'b1;
        op       = o;
        A        = a;
        B        = b;
        #1;
        check({tag, "_in_ready"}, in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic expect_result(input string tag, input logic [7:0] r, input logic [3:0] f);
        check({tag, "_out_valid"}, out_valid, 1);
        check({tag, "_R"}, R, r);
        check({tag, "_flags"}, flags, f);
    endtask

    // Wait for a MUL result, checking latency and that input stays blocked meanwhile.
    task automatic wait_mul(input string tag);
        int  waited;
        bit  ready_seen;
        waited     = 0;
        ready_seen = 1'b0;
        while (!out_valid && waited < 30) begin
            if (in_ready) ready_seen = 1'b1;
            waited++;
            @(negedge clk);
        end
        check({tag, "_latency"}, waited, 8);
        check({tag, "_blocked"}, ready_seen, 0);
    endtask

    initial begin
        int  seen;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        A         = '0;
        B         = '0;
        op        = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_R", R, 0);
        check("rst_flags", flags, 0);
        rst_n = 1'b1;

        // ADD with signed overflow
        issue("add", 3'd0, 8'h6A, 8'h3B);
        expect_result("add", 8'hA5, 4'b1010);
        @(negedge clk);
        check("add_consumed", out_valid, 0);

        // SUB both directions, then one with signed overflow
        issue("sub1", 3'd1, 8'h6A, 8'h3B);
        expect_result("sub1", 8'h2F, 4'b0000);
        issue("sub2", 3'd1, 8'h3B, 8'h6A);
        expect_result("sub2", 8'hD1, 4'b0110);
        issue("sub3", 3'd1, 8'h80, 8'h01);
        expect_result("sub3", 8'h7F, 4'b1000);

        // Logic ops
        issue("and", 3'd2, 8'hF0, 8'h3C);
        expect_result("and", 8'h30, 4'b0000);
        issue("or", 3'd3, 8'h80, 8'h01);
        expect_result("or", 8'h81, 4'b0010);

        // Shifts including boundary amounts
        issue("shl3", 3'd5, 8'h6A, 8'd3);
        expect_result("shl3", 8'h50, 4'b0100);
        issue("shr1", 3'd6, 8'h6A, 8'd1);
        expect_result("shr1", 8'h35, 4'b0000);
        issue("shl8", 3'd5, 8'h6A, 8'd8);
        expect_result("shl8", 8'h00, 4'b0001);
        issue("shl0", 3'd5, 8'h6A, 8'd0);
        expect_result("shl0", 8'h6A, 4'b0000);
        issue("shr9", 3'd6, 8'hFF, 8'd9);
        expect_result("shr9", 8'h00, 4'b0001);

        // MUL with high-half overflow, then a small product
        issue("mul1", 3'd7, 8'h6A, 8'h3B);
        check("mul1_ready_low", in_ready, 0);
        wait_mul("mul1");
        expect_result("mul1", 8'h6E, 4'b0100);
        check("mul1_ready_back", in_ready, 1);
        issue("mul2", 3'd7, 8'h0F, 8'h03);
        wait_mul("mul2");
        expect_result("mul2", 8'h2D, 4'b0000);

        // Backpressure: XOR result held while an ADD waits
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        op        = 3'd4;
        A         = 8'hFF;
        B         = 8'hFF;
        #1;
        check("xor_in_ready", in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        op = 3'd0;
        A  = 8'h01;
        B  = 8'h02;
        #1;
        expect_result("xor", 8'h00, 4'b0001);
        check("bp_ready0", in_ready, 0);
        for (int i = 1; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("bp_hold%0d_R", i), R, 8'h00);
            check($sformatf("bp_hold%0d_valid", i), out_valid, 1);
            check($sformatf("bp_hold%0d_ready", i), in_ready, 0);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        expect_result("bp_add", 8'h03, 4'b0000);
        @(negedge clk);
        check("bp_no_dup", out_valid, 0);

        // Reset in the middle of a MUL
        issue("mulrst", 3'd7, 8'h6A, 8'h3B);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mulrst_out_valid", out_valid, 0);
        check("mulrst_R", R, 0);
        check("mulrst_flags", flags, 0);
        check("mulrst_in_ready", in_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("mulrst_ready_after", in_ready, 1);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("mulrst_no_result", seen, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
